i2c_master_byte_ctrl: RTL and testbench



---
 rtl/i2c_pkg.sv | 38 +++
 rtl/i2c_phase_gen.sv | 47 ++++
 rtl/i2c_master_byte_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_i2c_master_byte_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// ============================================================================
// Package     : i2c_pkg
// Description : Shared types and constants for the single-byte I2C master:
//               FSM state encoding, quarter-slot indices, R/W and ACK levels.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2c_pkg;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'd0,
      ST_START = 4'd1,
      ST_ADDR  = 4'd2,
      ST_AACK  = 4'd3,
      ST_WDATA = 4'd4,
      ST_WACK  = 4'd5,
      ST_RDATA = 4'd6,
      ST_RNACK = 4'd7,
      ST_STOP  = 4'd8,
      ST_DONE  = 4'd9
   } state_t;

   // Quarter index inside one bit slot: SCL low in Q0/Q1, high in Q2/Q3
   localparam logic [1:0] Q0 = 2'd0;
   localparam logic [1:0] Q1 = 2'd1;
   localparam logic [1:0] Q2 = 2'd2;
   localparam logic [1:0] Q3 = 2'd3;

   localparam logic RW_WRITE = 1'b0;
   localparam logic RW_READ  = 1'b1;

   localparam logic ACK  = 1'b0;
   localparam logic NACK = 1'b1;

endpackage

`default_nettype wire

// File: rtl/i2c_phase_gen.sv
// ============================================================================
// Module      : i2c_phase_gen
// Description : SCL quarter-period generator. A divider counts 0..CLK_DIV-1
//               and emits qtick on the last count; a 2-bit quarter index
//               advances on every qtick. Both are held at zero while run=0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_phase_gen
   import i2c_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run,
   output logic       qtick,
   output logic [1:0] q
);

   localparam int            CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt;

   assign qtick = run && (cnt == CNT_MAX);

   // Divider and quarter index; both restart from zero whenever run drops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         q   <= Q0;
      end else if (!run) begin
         cnt <= '0;
         q   <= Q0;
      end else if (qtick) begin
         cnt <= '0;
         q   <= q + 2'd1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/i2c_master_byte_ctrl.sv
// ============================================================================
// Module      : i2c_master_byte_ctrl
// Description : Single-byte I2C master. Runs START, address+R/W, ACK check,
//               one data byte (write or read), master NACK on read, STOP.
//               Each bit occupies four SCL quarters of CLK_DIV clocks.
// Config      : `define I2C_SDA_SYNC_EN adds a 2-flop SDA input synchronizer
//               and moves the sample point to q3 entry + 2 clk
//               (needs CLK_DIV >= 3). Bus timing is unchanged.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_master_byte_ctrl
   import i2c_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [6:0] addr,
   input  logic       rw,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       busy,
   output logic       done,
   output logic       ack_err,
   output logic       scl,
   inout  wire        sda
);

   state_t     state;
   state_t     state_nx;

   logic       run;
   logic       qtick;
   logic [1:0] q;
   logic       slot_end;
   logic       q3_entry;
   logic       accept;

   logic [6:0] addr_q;
   logic       rw_q;
   logic [7:0] wdata_q;
   logic [2:0] bit_cnt;
   logic       last_bit;
   logic [7:0] tx_byte;
   logic       tx_bit;
   logic [7:0] rx_sr;
   logic       samp;
   logic       sda_low;
   logic       sda_in;
   logic       samp_stb;

   // Divider only runs while a transaction is on the bus
   assign run = (state != ST_IDLE) && (state != ST_DONE);

   i2c_phase_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_phase_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .run   (run),
      .qtick (qtick),
      .q     (q)
   );

   assign slot_end = qtick && (q == Q3);
   assign q3_entry = qtick && (q == Q2);
   assign accept   = (state == ST_IDLE) && start;
   assign last_bit = (bit_cnt == 3'd7);
   assign tx_byte  = (state == ST_WDATA) ? wdata_q : {addr_q, rw_q};
   assign tx_bit   = tx_byte[3'd7 - bit_cnt];

   // Open-drain: only ever pull low or release
   assign sda = sda_low ? 1'b0 : 1'bz;

`ifdef I2C_SDA_SYNC_EN
   if (CLK_DIV < 3) begin : g_div_too_small
      $error("i2c_master_byte_ctrl: I2C_SDA_SYNC_EN requires CLK_DIV >= 3");
   end

   logic [1:0] sda_sync;
   logic [1:0] stb_dly;

   // Two-flop SDA synchronizer and a matching 2-clk delay of the sample strobe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sda_sync <= 2'b11;
         stb_dly  <= 2'b00;
      end else begin
         sda_sync <= {sda_sync[0], sda};
         stb_dly  <= {stb_dly[0], q3_entry};
      end
   end

   assign sda_in   = sda_sync[1];
   assign samp_stb = stb_dly[1];
`else
   assign sda_in   = sda;
   assign samp_stb = q3_entry;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state decode and SCL/SDA drive per state and quarter
   always_comb begin
      state_nx = state;
      scl      = 1'b1;
      sda_low  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) state_nx = ST_START;
         end
         ST_START: begin
            // SCL stays high; SDA falls at q2 entry to form the START
            sda_low = q[1];
            if (slot_end) state_nx = ST_ADDR;
         end
         ST_ADDR: begin
            scl     = q[1];
            sda_low = ~tx_bit;
            if (slot_end && last_bit) state_nx = ST_AACK;
         end
         ST_AACK: begin
            scl = q[1];
            if (slot_end) begin
               if (samp == NACK)         state_nx = ST_STOP;
               else if (rw_q == RW_READ) state_nx = ST_RDATA;
               else                      state_nx = ST_WDATA;
            end
         end
         ST_WDATA: begin
            scl     = q[1];
            sda_low = ~tx_bit;
            if (slot_end && last_bit) state_nx = ST_WACK;
         end
         ST_WACK: begin
            scl = q[1];
            if (slot_end) state_nx = ST_STOP;
         end
         ST_RDATA: begin
            scl = q[1];
            if (slot_end && last_bit) state_nx = ST_RNACK;
         end
         ST_RNACK: begin
            scl = q[1];
            if (slot_end) state_nx = ST_STOP;
         end
         ST_STOP: begin
            // SDA held low until q3 entry, then released while SCL is high
            scl     = q[1];
            sda_low = (q != Q3);
            if (slot_end) state_nx = ST_DONE;
         end
         ST_DONE: begin
            state_nx = ST_IDLE;
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // Capture the request so later input changes cannot disturb the transfer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= 7'd0;
         rw_q    <= RW_WRITE;
         wdata_q <= 8'd0;
      end else if (accept) begin
         addr_q  <= addr;
         rw_q    <= rw;
         wdata_q <= wdata;
      end
   end

   // Bit position within the current byte; wraps to zero after bit 7
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt <= 3'd0;
      end else if (slot_end) begin
         if ((state == ST_ADDR) || (state == ST_WDATA) || (state == ST_RDATA)) begin
            bit_cnt <= bit_cnt + 3'd1;
         end else begin
            bit_cnt <= 3'd0;
         end
      end
   end

   // SDA sample point: latest bit level plus the read shift register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         samp  <= 1'b1;
         rx_sr <= 8'd0;
      end else if (samp_stb) begin
         samp <= sda_in;
         if (state == ST_RDATA) rx_sr <= {rx_sr[6:0], sda_in};
      end
   end

   // Host-visible results: read byte and sticky acknowledge error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata   <= 8'd0;
         ack_err <= 1'b0;
      end else begin
         if (state == ST_RNACK && slot_end) rdata <= rx_sr;
         if (accept) begin
            ack_err <= 1'b0;
         end else if (slot_end && ((state == ST_AACK) || (state == ST_WACK)) && (samp == NACK)) begin
            ack_err <= 1'b1;
         end
      end
   end

   // Handshake flags registered from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= (state_nx != ST_IDLE);
         done <= (state_nx == ST_DONE);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_i2c_master_byte_ctrl.sv
// ============================================================================
// Module      : tb_i2c_master_byte_ctrl
// Description : Bench for i2c_master_byte_ctrl with a behavioural I2C slave,
//               pull-ups on both SDA lines and an expected-result queue.
//               A second instance exercises the minimum usable CLK_DIV.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_master_byte_ctrl;

   localparam int CD = 4;
`ifdef I2C_SDA_SYNC_EN
   localparam int CDF = 3;
`else
   localparam int CDF = 1;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       start_m, start_f;
   logic [6:0] addr_in;
   logic       rw_in;
   logic [7:0] wdata_in;
   logic [7:0] rdata_m, rdata_f;
   logic       busy_m, busy_f, done_m, done_f, ack_err_m, ack_err_f, scl_m, scl_f;
   wire        sda_m, sda_f;

   // Slave configuration and state
   logic       sel;
   logic       sl_present, sl_dnack, sl_reset;
   logic [6:0] sl_addr;
   logic [7:0] sl_rd;
   logic       sl_low, sl_active, sl_acked, sl_mack, p_scl, p_sda;
   logic [7:0] sl_abyte, sl_dbyte;
   int         sl_f, sl_r, starts, stops, done_cnt;
   logic       bscl, bsda;

   logic [7:0] mdl_rdata_m, mdl_rdata_f;

   typedef struct {
      logic [7:0] abyte;
      logic [7:0] dbyte;
      logic       chk_data;
      logic       ack_err;
      logic [7:0] rdata;
      int         lat;
      int         rises;
      logic       chk_mack;
   } exp_t;
   exp_t sb[$];

   int n_checks = 0;
   int n_pass   = 0;

   i2c_master_byte_ctrl #(.CLK_DIV(CD)) dut (
      .clk(clk), .rst_n(rst_n), .start(start_m), .addr(addr_in), .rw(rw_in),
      .wdata(wdata_in), .rdata(rdata_m), .busy(busy_m), .done(done_m),
      .ack_err(ack_err_m), .scl(scl_m), .sda(sda_m)
   );

   i2c_master_byte_ctrl #(.CLK_DIV(CDF)) dut_fast (
      .clk(clk), .rst_n(rst_n), .start(start_f), .addr(addr_in), .rw(rw_in),
      .wdata(wdata_in), .rdata(rdata_f), .busy(busy_f), .done(done_f),
      .ack_err(ack_err_f), .scl(scl_f), .sda(sda_f)
   );

   pullup (sda_m);
   pullup (sda_f);
   assign sda_m = (sl_low && !sel) ? 1'b0 : 1'bz;
   assign sda_f = (sl_low &&  sel) ? 1'b0 : 1'bz;
   assign bscl  = sel ? scl_f : scl_m;
   assign bsda  = sel ? sda_f : sda_m;

   // Behavioural slave: slots counted by SCL falls (drive) and rises (sample)
   always @(negedge clk) begin
      if (sl_reset) begin
         sl_active <= 1'b0; sl_low <= 1'b0; sl_acked <= 1'b0; sl_mack <= 1'b0;
         sl_f <= 0; sl_r <= 0; sl_abyte <= 8'd0; sl_dbyte <= 8'd0;
         starts <= 0; stops <= 0; done_cnt <= 0;
      end else begin
         if (done_m || done_f) done_cnt <= done_cnt + 1;
         if (p_scl && bscl && p_sda && !bsda) begin
            sl_active <= 1'b1; sl_f <= 0; sl_r <= 0; sl_low <= 1'b0;
            sl_acked <= 1'b0; sl_abyte <= 8'd0; sl_dbyte <= 8'd0; sl_mack <= 1'b0;
            starts <= starts + 1;
         end else if (p_scl && bscl && !p_sda && bsda) begin
            sl_active <= 1'b0; sl_low <= 1'b0;
            stops <= stops + 1;
         end else if (sl_active && p_scl && !bscl) begin
            if (sl_f == 8) begin
               sl_acked <= sl_present && (sl_abyte[7:1] == sl_addr);
               sl_low   <= sl_present && (sl_abyte[7:1] == sl_addr);
            end else if (sl_f >= 9 && sl_f <= 16) begin
               sl_low <= sl_acked && sl_abyte[0] && !sl_rd[16 - sl_f];
            end else if (sl_f == 17) begin
               sl_low <= sl_acked && !sl_abyte[0] && !sl_dnack;
            end else begin
               sl_low <= 1'b0;
            end
            sl_f <= sl_f + 1;
         end else if (sl_active && !p_scl && bscl) begin
            if (sl_r < 8)                    sl_abyte <= {sl_abyte[6:0], bsda};
            else if (sl_r >= 9 && sl_r <= 16) sl_dbyte <= {sl_dbyte[6:0], bsda};
            else if (sl_r == 17)             sl_mack  <= bsda;
            sl_r <= sl_r + 1;
         end
      end
      p_scl <= bscl;
      p_sda <= bsda;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // One transaction: push expectations, drive start, wait for done, compare
   task automatic run_txn(input logic s, input logic [6:0] a, input logic r,
                          input logic [7:0] wd, input logic dbl);
      exp_t e, g;
      int   cd, n, st0, sp0, dn0;
      logic seen, acked;
      cd    = s ? CDF : CD;
      acked = sl_present && (a == sl_addr);
      if (acked && r) begin
         if (s) mdl_rdata_f = sl_rd; else mdl_rdata_m = sl_rd;
      end
      e.abyte    = {a, r};
      e.dbyte    = r ? sl_rd : wd;
      e.chk_data = acked;
      e.ack_err  = !acked || (!r && sl_dnack);
      e.rdata    = s ? mdl_rdata_f : mdl_rdata_m;
      e.lat      = (acked ? 80 : 44) * cd + 1;
      e.rises    = acked ? 19 : 10;
      e.chk_mack = acked && r;
      sb.push_back(e);

      sel = s;
      @(negedge clk);
      st0 = starts; sp0 = stops; dn0 = done_cnt;
      addr_in = a; rw_in = r; wdata_in = wd;
      if (s) start_f = 1'b1; else start_m = 1'b1;
      @(negedge clk);
      start_m = 1'b0; start_f = 1'b0;
      addr_in = ~a; rw_in = ~r; wdata_in = ~wd;
      n = 0; seen = 1'b0;
      while (!seen && n < 120 * cd + 20) begin
         if ((s ? done_f : done_m) === 1'b1) begin
            seen = 1'b1;
         end else begin
            n++;
            start_m = dbl && (n == 10 || n == 50);
            @(negedge clk);
         end
      end
      start_m = 1'b0;
      #1;
      g = sb.pop_front();
      check_val("done_latency", seen ? n + 1 : 0, g.lat);
      check_val("ack_err", s ? ack_err_f : ack_err_m, g.ack_err);
      check_val("rdata", s ? rdata_f : rdata_m, g.rdata);
      check_val("addr_byte", sl_abyte, g.abyte);
      if (g.chk_data) check_val("data_byte", sl_dbyte, g.dbyte);
      if (g.chk_mack) check_val("master_nack", sl_mack, 1);
      check_val("scl_rises", sl_r, g.rises);
      check_val("stop_seen", stops - sp0, 1);
      @(negedge clk);
      check_val("busy_after_done", s ? busy_f : busy_m, 0);
      check_val("done_width", s ? done_f : done_m, 0);
      if (dbl) repeat (100) @(negedge clk);
      #1;
      check_val("start_count", starts - st0, 1);
      check_val("done_count", done_cnt - dn0, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; sl_reset = 1'b1; sel = 1'b0;
      start_m = 1'b0; start_f = 1'b0; addr_in = 7'd0; rw_in = 1'b0; wdata_in = 8'd0;
      sl_present = 1'b1; sl_addr = 7'h50; sl_rd = 8'hAA; sl_dnack = 1'b0;
      mdl_rdata_m = 8'h00; mdl_rdata_f = 8'h00;
      repeat (3) @(negedge clk);
      check_val("rst_scl", scl_m, 1);
      check_val("rst_sda", sda_m, 1);
      check_val("rst_busy", busy_m, 0);
      check_val("rst_done", done_m, 0);
      check_val("rst_ack_err", ack_err_m, 0);
      check_val("rst_rdata", rdata_m, 8'h00);
      check_val("rst_scl_fast", scl_f, 1);
      rst_n = 1'b1; sl_reset = 1'b0;
      repeat (3) @(negedge clk);

      run_txn(1'b0, 7'h50, 1'b0, 8'hA5, 1'b0);   // write, ACKed
      run_txn(1'b0, 7'h50, 1'b1, 8'h00, 1'b0);   // read 0xAA
      sl_present = 1'b0;
      run_txn(1'b0, 7'h3C, 1'b1, 8'h00, 1'b0);   // no slave: address NACK
      sl_present = 1'b1; sl_dnack = 1'b1;
      run_txn(1'b0, 7'h50, 1'b0, 8'hC3, 1'b0);   // data byte NACKed
      sl_dnack = 1'b0;
      run_txn(1'b0, 7'h50, 1'b0, 8'h3C, 1'b1);   // extra starts while busy

      // Reset in the middle of the address byte
      @(negedge clk);
      addr_in = 7'h50; rw_in = 1'b0; wdata_in = 8'hFF; start_m = 1'b1;
      @(negedge clk);
      start_m = 1'b0;
      repeat (101) @(negedge clk);
      check_val("pre_rst_scl", scl_m, 0);
      check_val("pre_rst_busy", busy_m, 1);
      rst_n = 1'b0;
      #1;
      check_val("abort_scl", scl_m, 1);
      check_val("abort_sda", sda_m, 1);
      check_val("abort_busy", busy_m, 0);
      check_val("abort_rdata", rdata_m, 8'h00);
      sl_reset = 1'b1; mdl_rdata_m = 8'h00;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      sl_reset = 1'b0;
      @(negedge clk);
      run_txn(1'b0, 7'h50, 1'b0, 8'h5A, 1'b0);   // normal write after reset

      sl_addr = 7'h00;
      run_txn(1'b1, 7'h00, 1'b0, 8'h00, 1'b0);   // minimum divider instance

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
